// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the ALU arbiter:
//   - datapath and select-code widths
//   - select-code constants for arithmetic mode (mode = 0) and logic mode
//     (mode = 1). The two modes reuse the same numeric codes.
//   - sequencer FSM state type
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    // Arithmetic unit select codes (mode = 0)
    localparam logic [SEL_W-1:0] SEL_ADD    = 4'h0;  // a + b + carry_in
    localparam logic [SEL_W-1:0] SEL_SUB    = 4'h1;  // a - b - carry_in, carry_out = borrow
    localparam logic [SEL_W-1:0] SEL_INC    = 4'h2;  // a + 1
    localparam logic [SEL_W-1:0] SEL_DEC    = 4'h3;  // a - 1, carry_out = borrow
    localparam logic [SEL_W-1:0] SEL_PASS_A = 4'h4;  // a

    // Logic unit select codes (mode = 1)
    localparam logic [SEL_W-1:0] SEL_AND    = 4'h0;
    localparam logic [SEL_W-1:0] SEL_OR     = 4'h1;
    localparam logic [SEL_W-1:0] SEL_XOR    = 4'h2;
    localparam logic [SEL_W-1:0] SEL_NOT_A  = 4'h3;
    localparam logic [SEL_W-1:0] SEL_NAND   = 4'h4;
    localparam logic [SEL_W-1:0] SEL_NOR    = 4'h5;
    localparam logic [SEL_W-1:0] SEL_XNOR   = 4'h6;
    localparam logic [SEL_W-1:0] SEL_PASS_B = 4'h7;

    typedef enum logic [1:0] {
        IDLE,   // nothing in flight
        EXEC,   // ALU evaluates the registered operands
        RESP    // response register full
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Request/response bundle between NREQ clients and the ALU arbiter.
//   req_valid/req_ready : per-requester handshake (req_ready is one-hot)
//   req_a/req_b         : 16-bit operands, slice i = [16i+15:16i]
//   req_select          : 4-bit select code, slice i = [4i+3:4i]
//   req_mode/req_chain  : logic-mode flag and carry-chain flag per requester
//   rsp_*               : shared response channel tagged with rsp_id
// Modports: master = client side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [DATA_W*NREQ-1:0] req_a;
    logic [DATA_W*NREQ-1:0] req_b;
    logic [SEL_W*NREQ-1:0]  req_select;
    logic [NREQ-1:0]        req_mode;
    logic [NREQ-1:0]        req_chain;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_carry;
    logic                   rsp_compare;

    modport master (
        output req_valid, req_a, req_b, req_select, req_mode, req_chain, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_compare
    );

    modport slave (
        input  req_valid, req_a, req_b, req_select, req_mode, req_chain, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_compare
    );

endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational 16-bit ALU with an arithmetic unit and a logic unit.
//   a, b      : operands
//   select    : operation code (see alu_pkg)
//   mode      : 0 = arithmetic, 1 = logic
//   carry_in  : carry (add) or borrow (sub) into the arithmetic unit
//   alu_out   : result
//   carry_out : arithmetic carry / borrow out; always 0 in logic mode
//   compare   : 1 when a == b
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  select,
    input  logic              mode,
    input  logic              carry_in,
    output logic [DATA_W-1:0] alu_out,
    output logic              carry_out,
    output logic              compare
);

    logic [DATA_W:0]   ext_a;
    logic [DATA_W:0]   ext_b;
    logic [DATA_W:0]   ext_c;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] logic_res;

    // One extra bit holds the carry (add) or the borrow (sub, dec).
    assign ext_a = {1'b0, a};
    assign ext_b = {1'b0, b};
    assign ext_c = {{DATA_W{1'b0}}, carry_in};

    always_comb begin
        // NOTE: defaults come first so every path assigns the output and no latch is inferred.
        sum = '0;
        case (select)
            SEL_ADD:    sum = ext_a + ext_b + ext_c;
            SEL_SUB:    sum = ext_a - ext_b - ext_c;
            SEL_INC:    sum = ext_a + (DATA_W+1)'(1);
            SEL_DEC:    sum = ext_a - (DATA_W+1)'(1);
            SEL_PASS_A: sum = ext_a;
            default:    sum = '0;
        endcase
    end

    always_comb begin
        logic_res = '0;
        case (select)
            SEL_AND:    logic_res = a & b;
            SEL_OR:     logic_res = a | b;
            SEL_XOR:    logic_res = a ^ b;
            SEL_NOT_A:  logic_res = ~a;
            SEL_NAND:   logic_res = ~(a & b);
            SEL_NOR:    logic_res = ~(a | b);
            SEL_XNOR:   logic_res = ~(a ^ b);
            SEL_PASS_B: logic_res = b;
            default:    logic_res = '0;
        endcase
    end

    assign alu_out   = mode ? logic_res : sum[DATA_W-1:0];
    assign carry_out = mode ? 1'b0 : sum[DATA_W];
    assign compare   = (a == b);

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker.
//   req   : request vector
//   last  : index of the most recent winner; search starts at last+1
//   en    : when low, no grant is produced
//   grant : one-hot grant to the first set req bit from last+1 with wrap
//   idx   : binary index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Walk last+1, last+2, ... wrapping, ending at last itself.
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(last) + i) % NREQ);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between NREQ requesters. Requests are granted round-robin,
// registered, executed for one cycle, and returned on a shared response
// channel tagged with the requester id. A per-requester carry register lets
// each client build multi-word add/sub chains.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : alu_arbiter_if slave (request handshake + response channel)
//   busy       : high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus,
    output logic          busy
);

    state_t            state_q, state_d;
    logic [IDW-1:0]    last_q;
    logic [IDW-1:0]    win_idx;
    logic [NREQ-1:0]   grant;
    logic              accept_window;
    logic              accept;

    // Operation registers
    logic [DATA_W-1:0] a_q, b_q;
    logic [SEL_W-1:0]  sel_q;
    logic              mode_q, cin_q;
    logic [IDW-1:0]    id_q;

    // Per-requester stored carry
    logic [NREQ-1:0]   carry_q;

    // ALU outputs
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry, alu_compare;

    // Response register
    logic [IDW-1:0]    rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_carry_q, rsp_compare_q;

    // Unpacked views of the flat request buses
    logic [DATA_W-1:0] req_a_arr   [NREQ];
    logic [DATA_W-1:0] req_b_arr   [NREQ];
    logic [SEL_W-1:0]  req_sel_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign req_a_arr[g]   = bus.req_a[g*DATA_W +: DATA_W];
        assign req_b_arr[g]   = bus.req_b[g*DATA_W +: DATA_W];
        assign req_sel_arr[g] = bus.req_select[g*SEL_W +: SEL_W];
    end

    // A new op can enter only when the op registers are free: in IDLE, or
    // when the held response is consumed this very cycle. rst_n gates the
    // grant so req_ready stays low while reset is asserted.
    assign accept_window = rst_n &&
                           ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req   (bus.req_valid),
        .last  (last_q),
        .en    (accept_window),
        .grant (grant),
        .idx   (win_idx)
    );

    assign accept        = |grant;
    assign bus.req_ready = grant;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            if (accept) last_q <= win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= '0;
            mode_q <= 1'b0;
            cin_q  <= 1'b0;
            id_q   <= '0;
        end else if (accept) begin
            a_q    <= req_a_arr[win_idx];
            b_q    <= req_b_arr[win_idx];
            sel_q  <= req_sel_arr[win_idx];
            mode_q <= bus.req_mode[win_idx];
            cin_q  <= bus.req_chain[win_idx] & carry_q[win_idx];
            id_q   <= win_idx;
        end
    end

    alu u_alu (
        .a         (a_q),
        .b         (b_q),
        .select    (sel_q),
        .mode      (mode_q),
        .carry_in  (cin_q),
        .alu_out   (alu_out),
        .carry_out (alu_carry),
        .compare   (alu_compare)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the carry array is reset explicitly because a reset must discard every stored chain carry.
        if (!rst_n) begin
            carry_q       <= '0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_compare_q <= 1'b0;
        end else if (state_q == EXEC) begin
            // Logic ops return carry_out = 0, so they break the chain.
            carry_q[id_q] <= alu_carry;
            rsp_id_q      <= id_q;
            rsp_data_q    <= alu_out;
            rsp_carry_q   <= alu_carry;
            rsp_compare_q <= alu_compare;
        end
    end

    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_carry   = rsp_carry_q;
    assign bus.rsp_compare = rsp_compare_q;
    assign busy            = (state_q != IDLE);

endmodule
